// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C request arbiter: state codes,
// command field widths and the per-requester command record.
package i2c_pkg;

    localparam int LEN_W = 4;
    localparam int DEV_W = 7;
    localparam int REG_W = 8;

    typedef enum logic [2:0] {
        ST_ARB     = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic             rd;
        logic [DEV_W-1:0] dev;
        logic [REG_W-1:0] reg_addr;
        logic [LEN_W-1:0] len;
    } i2c_cmd_t;

    // Remaining-byte counter never wraps below zero.
    function automatic logic [LEN_W-1:0] len_sat_dec(input logic [LEN_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic             valid
);

    int               sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        win_oh = '0;
        valid  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            idx = PTR_W'((sum >= NREQ) ? sum - NREQ : sum);
            if (!valid && req[idx]) begin
                win_oh[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C interface FSM
// among NREQ requesters; all outputs registered.
//
// state   | meaning
// ARB     | idle, grant when FSM READY and any REQ set
// LAUNCH  | EXECUTE high, waiting for FSM to leave Idle
// RUN     | FSM busy, counting INCR pulses toward last byte
// RELEASE | EXECUTE dropped, one cycle for FSM to return to Idle
// DONE    | DONE/ERR pulse to granted requester, grant cleared
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TMO_W = 16
) (
    input  logic              CLK,
    input  logic              RST_B,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   REQ_RD,
    input  logic [7*NREQ-1:0] REQ_DEV,
    input  logic [8*NREQ-1:0] REQ_REG,
    input  logic [4*NREQ-1:0] REQ_LEN,
    input  logic              I2C_READY,
    input  logic              I2C_INCR,
    output logic              EXECUTE,
    output logic              READ,
    output logic              WRITE,
    output logic              LAST_BYTE,
    output logic [6:0]        DEV_ADDR,
    output logic [7:0]        REG_ADDR,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   DONE,
    output logic              ERR,
    output logic              BUSY,
    output logic [2:0]        ARB_STATE
);

    localparam int PTR_W = $clog2(NREQ);
    // Leaving on the cycle the counter would reach all-ones gives exactly
    // 2^TMO_W-1 cycles of EXECUTE.
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_err_q, tmo_err_d;
    logic             exec_q, exec_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             last_q, last_d;
    logic [DEV_W-1:0] dev_q, dev_d;
    logic [REG_W-1:0] reg_q, reg_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    i2c_cmd_t         cmd_arr [NREQ];
    i2c_cmd_t         win_cmd;
    logic [NREQ-1:0]  win_oh;
    logic             win_valid;

    for (genvar g = 0; g < NREQ; g++) begin : g_cmd
        assign cmd_arr[g] = {REQ_RD[g],
                             REQ_DEV[DEV_W*g +: DEV_W],
                             REQ_REG[REG_W*g +: REG_W],
                             REQ_LEN[LEN_W*g +: LEN_W]};
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (REQ),
        .ptr    (ptr_q),
        .win_oh (win_oh),
        .valid  (win_valid)
    );

    always_comb begin
        win_cmd  = '0;
        ptr_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_cmd  = cmd_arr[i];
                ptr_next = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        exec_d    = exec_q;
        read_d    = read_q;
        write_d   = write_q;
        last_d    = last_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (I2C_READY && win_valid) begin
                    state_d   = ST_LAUNCH;
                    gnt_d     = win_oh;
                    ptr_d     = ptr_next;
                    read_d    = win_cmd.rd;
                    write_d   = ~win_cmd.rd;
                    dev_d     = win_cmd.dev;
                    reg_d     = win_cmd.reg_addr;
                    cnt_d     = win_cmd.len;
                    last_d    = (win_cmd.len == '0);
                    exec_d    = 1'b1;
                    tmo_d     = '0;
                    tmo_err_d = 1'b0;
                end
            end
            ST_LAUNCH, ST_RUN: begin
                tmo_d = tmo_q + 1'b1;
                if (I2C_INCR) begin
                    cnt_d  = len_sat_dec(cnt_q);
                    last_d = (cnt_d == '0);
                end
                if (tmo_q == TMO_PRE) begin
                    state_d   = ST_RELEASE;
                    exec_d    = 1'b0;
                    tmo_err_d = 1'b1;
                end else if (state_q == ST_LAUNCH && !I2C_READY) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN && I2C_READY) begin
                    state_d = ST_RELEASE;
                    exec_d  = 1'b0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_DONE;
                done_d  = gnt_q;
                err_d   = tmo_err_q;
            end
            ST_DONE: begin
                state_d = ST_ARB;
                gnt_d   = '0;
                read_d  = 1'b0;
                write_d = 1'b0;
                last_d  = 1'b0;
            end
            default: begin
                state_d = ST_ARB;
                exec_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_ARB);
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
            exec_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            last_q    <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
            exec_q    <= exec_d;
            read_q    <= read_d;
            write_q   <= write_d;
            last_q    <= last_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign EXECUTE   = exec_q;
    assign READ      = read_q;
    assign WRITE     = write_q;
    assign LAST_BYTE = last_q;
    assign DEV_ADDR  = dev_q;
    assign REG_ADDR  = reg_q;
    assign GNT       = gnt_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign BUSY      = busy_q;
    assign ARB_STATE = state_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: directed requests, a simple I2C FSM
// model, and grant/done monitors popping hand-computed expectations.
module tb_i2c_req_arbiter;

    localparam int NREQ  = 4;
    localparam int TMO_W = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  req, req_rd;
    logic [27:0] req_dev;
    logic [31:0] req_reg;
    logic [15:0] req_len;
    logic        i2c_ready, i2c_incr;
    logic        execute, dut_read, dut_write, last_byte;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic [3:0]  gnt, done;
    logic        err, busy;
    logic [2:0]  arb_state;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
        .CLK(clk), .RST_B(rst_b), .REQ(req), .REQ_RD(req_rd), .REQ_DEV(req_dev),
        .REQ_REG(req_reg), .REQ_LEN(req_len), .I2C_READY(i2c_ready), .I2C_INCR(i2c_incr),
        .EXECUTE(execute), .READ(dut_read), .WRITE(dut_write), .LAST_BYTE(last_byte),
        .DEV_ADDR(dev_addr), .REG_ADDR(reg_addr), .GNT(gnt), .DONE(done), .ERR(err),
        .BUSY(busy), .ARB_STATE(arb_state)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       rd;
        logic [6:0] dev;
        logic [7:0] ra;
    } exp_grant_t;

    typedef struct {
        logic [3:0] done;
        logic       err;
    } exp_done_t;

    exp_grant_t exp_g[$];
    exp_done_t  exp_d[$];

    int n_tests = 0, n_fail = 0, n_grants = 0, n_dones = 0;
    bit stuck = 0, ready_hold = 0, hold_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters release REQ while their DONE is visible (unless told to keep requesting).
    task automatic tick_main();
        tick();
        if (!hold_req) req = req & ~done;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [3:0] len,
                           input bit push_done, input logic exp_err);
        req_rd[i]         = rd;
        req_dev[7*i +: 7] = dev;
        req_reg[8*i +: 8] = ra;
        req_len[4*i +: 4] = len;
        exp_g.push_back('{gnt: 4'(1 << i), rd: rd, dev: dev, ra: ra});
        if (push_done) exp_d.push_back('{done: 4'(1 << i), err: exp_err});
    endtask

    task automatic wait_dones(input int target);
        for (int k = 0; k < 400; k++) begin
            if (n_dones >= target) break;
            tick_main();
        end
        chk("wait_done_count", n_dones, target);
    endtask

    // I2C interface FSM model: drops READY after seeing EXECUTE, emits one INCR per
    // non-last byte, then returns READY. In stuck mode READY stays low.
    initial begin
        int n;
        i2c_ready = 1'b1;
        i2c_incr  = 1'b0;
        forever begin
            tick();
            if (ready_hold) begin
                i2c_ready = 1'b0;
            end else if (execute && i2c_ready) begin
                n = 0;
                for (int g = 0; g < 4; g++) if (gnt[g]) n = int'(req_len[4*g +: 4]);
                i2c_ready = 1'b0;
                if (stuck) begin
                    while (stuck) tick();
                end else begin
                    chk("last_at_launch", last_byte, (n == 0));
                    for (int k = 0; k < n; k++) begin
                        tick();
                        i2c_incr = 1'b1;
                        tick();
                        i2c_incr = 1'b0;
                        chk("last_after_incr", last_byte, (k == n - 1));
                    end
                    tick();
                end
                i2c_ready = 1'b1;
                for (int k = 0; k < 50 && execute; k++) tick();
            end else begin
                i2c_ready = 1'b1;
            end
        end
    end

    // Grant monitor
    initial begin
        logic [3:0] pg;
        exp_grant_t e;
        pg = '0;
        forever begin
            @(negedge clk);
            if (gnt != 0 && pg == 0) begin
                n_grants++;
                if (exp_g.size() == 0) begin
                    chk("unexpected_grant", gnt, 0);
                end else begin
                    e = exp_g.pop_front();
                    chk("grant", gnt, e.gnt);
                    chk("grant_read", dut_read, e.rd);
                    chk("grant_write", dut_write, !e.rd);
                    chk("grant_dev", dev_addr, e.dev);
                    chk("grant_reg", reg_addr, e.ra);
                    chk("grant_exec", execute, 1);
                    chk("grant_busy", busy, 1);
                    chk("grant_state_launch", arb_state, 1);
                end
            end else if (gnt != 0 && gnt != pg) begin
                chk("grant_overlap", gnt, pg);
            end
            pg = gnt;
        end
    end

    // Done monitor
    initial begin
        logic [3:0] pd;
        logic       pe;
        logic [2:0] ps;
        exp_done_t  d;
        pd = '0; pe = 1'b0; ps = '0;
        forever begin
            @(negedge clk);
            if (done != 0) begin
                n_dones++;
                chk("done_single_cycle", pd, 0);
                chk("exec_low_at_and_before_done", {pe, execute}, 0);
                chk("state_done", arb_state, 4);
                chk("state_release_before_done", ps, 3);
                if (exp_d.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    d = exp_d.pop_front();
                    chk("done", done, d.done);
                    chk("done_err", err, d.err);
                end
            end
            pd = done;
            pe = execute;
            ps = arb_state;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int c;
        int gstart;
        rst_b = 1'b0; req = '0; req_rd = '0; req_dev = '0; req_reg = '0; req_len = '0;
        tick_main();
        tick_main();
        chk("rst_execute", execute, 0);
        chk("rst_read", dut_read, 0);
        chk("rst_write", dut_write, 0);
        chk("rst_last", last_byte, 0);
        chk("rst_dev", dev_addr, 0);
        chk("rst_reg", reg_addr, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", arb_state, 0);
        rst_b = 1'b1;
        tick_main();

        // Single write, requester 2, LEN=3
        set_req(2, 1'b0, 7'h52, 8'hA5, 4'd3, 1, 1'b0);
        req[2] = 1'b1;
        tick_main();
        chk("t1_exec", execute, 1);
        chk("t1_write", dut_write, 1);
        chk("t1_gnt", gnt, 4'b0100);
        wait_dones(1);
        chk("t1_idle_gnt", gnt, 0);
        chk("t1_idle_state", arb_state, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_write", dut_write, 0);

        // READY low at request time, ptr=3: requester 3 wins over 0 once READY returns
        ready_hold = 1;
        tick_main();
        tick_main();
        set_req(3, 1'b1, 7'h13, 8'h33, 4'd1, 1, 1'b0);
        set_req(0, 1'b0, 7'h20, 8'h00, 4'd2, 1, 1'b0);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick_main();
            chk("t2_no_grant_ready_low", gnt, 0);
        end
        ready_hold = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (i2c_ready) break;
        end
        chk("t2_ready_back", i2c_ready, 1);
        chk("t2_no_grant_at_ready_rise", gnt, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_gnt3_after_ready", gnt, 4'b1000);
        wait_dones(3);

        // Read, LEN=0
        set_req(0, 1'b1, 7'h50, 8'h10, 4'd0, 1, 1'b0);
        req[0] = 1'b1;
        tick_main();
        chk("t3_read", dut_read, 1);
        chk("t3_last_at_launch", last_byte, 1);
        wait_dones(4);

        // Timeout: FSM never returns READY
        stuck = 1;
        set_req(1, 1'b0, 7'h2A, 8'hF0, 4'd2, 1, 1'b1);
        req[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (execute) break;
            tick_main();
        end
        c = 0;
        for (int k = 0; k < 40; k++) begin
            if (!execute) break;
            c++;
            tick_main();
        end
        chk("t4_exec_cycles", c, 15);
        wait_dones(5);
        set_req(2, 1'b1, 7'h61, 8'h42, 4'd1, 1, 1'b0);
        req[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_main();
            chk("t4_no_grant_fsm_busy", gnt, 0);
        end
        stuck = 0;
        wait_dones(6);

        // Continuous requests after reset: 0,1,2,3,0
        rst_b = 1'b0;
        tick_main();
        tick_main();
        rst_b = 1'b1;
        hold_req = 1;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'(i & 1), 7'(8'h10 + i), 8'(8'h80 + i), 4'd1, 1, 1'b0);
        set_req(0, 1'b0, 7'h10, 8'h80, 4'd1, 1, 1'b0);
        gstart = n_grants;
        req = 4'hF;
        for (int k = 0; k < 300; k++) begin
            if (n_grants >= gstart + 5) break;
            tick_main();
        end
        chk("t5_grant_count", n_grants - gstart, 5);
        req = '0;
        hold_req = 0;
        wait_dones(11);

        // Reset during RUN, then rr pointer back at 0
        stuck = 1;
        set_req(1, 1'b1, 7'h07, 8'h77, 4'd0, 0, 1'b0);
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            if (arb_state == 3'd2) break;
            tick_main();
        end
        chk("t6_reached_run", arb_state, 2);
        chk("t6_exec_in_run", execute, 1);
        rst_b = 1'b0;
        tick_main();
        chk("t6_rst_exec", execute, 0);
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_state", arb_state, 0);
        chk("t6_rst_last", last_byte, 0);
        rst_b = 1'b1;
        req = '0;
        stuck = 0;
        for (int k = 0; k < 3; k++) tick_main();
        set_req(0, 1'b0, 7'h31, 8'h01, 4'd1, 1, 1'b0);
        set_req(2, 1'b1, 7'h32, 8'h02, 4'd0, 1, 1'b0);
        set_req(3, 1'b0, 7'h33, 8'h03, 4'd2, 1, 1'b0);
        req = 4'b1101;
        wait_dones(14);

        for (int k = 0; k < 5; k++) tick_main();
        chk("grant_queue_empty", exp_g.size(), 0);
        chk("done_queue_empty", exp_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Round-robin arbiter and transaction sequencer sharing one I2C interface FSM (CSR/EEPROM/sensor master) among NREQ requesters.
- Latches the winning command and drives the FSM's EXECUTE/READ/WRITE/LAST_BYTE.
- Counts INCR pulses to flag the last byte, detects completion from READY, returns a per-requester DONE/ERR.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO_W, 16, width of the transaction timeout counter; timeout = 2^TMO_W-1 cycles.

Ports:
- CLK  in  1  system clock
- RST_B  in  1  synchronous active-low reset
- REQ  in  NREQ  level request per requester; held until that requester's DONE
- REQ_RD  in  NREQ  1=read, 0=write, per requester
- REQ_DEV  in  7*NREQ  7-bit device address, requester i at [7i+6:7i]
- REQ_REG  in  8*NREQ  register/word address per requester
- REQ_LEN  in  4*NREQ  byte count minus 1 (0 means 1 byte, 15 means 16 bytes)
- I2C_READY  in  1  READY from I2C interface FSM
- I2C_INCR  in  1  INCR pulse from I2C FSM, one per completed non-last byte
- EXECUTE  out  1  to FSM
- READ  out  1  to FSM
- WRITE  out  1  to FSM
- LAST_BYTE  out  1  to FSM
- DEV_ADDR  out  7  latched device address to the shift datapath
- REG_ADDR  out  8  latched register address to the shift datapath
- GNT  out  NREQ  one-hot grant; held for the whole transaction
- DONE  out  NREQ  one-cycle completion pulse to the granted requester
- ERR  out  1  valid with DONE; 1 = timeout
- BUSY  out  1  arbiter not in ARB
- ARB_STATE  out  3  state code for debug

Behaviour:
- Reset, sampled on CLK rising edge with RST_B=0:
  - Outputs: EXECUTE, READ, WRITE, LAST_BYTE, GNT, DONE, ERR, BUSY all 0; DEV_ADDR and REG_ADDR 0.
  - Internal: state ARB, rr pointer 0 (requester 0 highest priority), byte counter 0, timeout counter 0.
  - A reset mid-transaction drops EXECUTE immediately. No DONE is issued.
- All outputs are registered.
- State ARB:
  - Grants only when I2C_READY=1 and any REQ is set.
  - Winner is the first set REQ searching from ptr upward, with wrap.
  - Latches READ=REQ_RD[w], WRITE=~REQ_RD[w], DEV_ADDR, REG_ADDR, and byte count = REQ_LEN[w].
  - Sets GNT[w], moves ptr to w+1 mod NREQ, goes to LAUNCH.
  - If no REQ is set, or I2C_READY=0, stays in ARB.
- State LAUNCH:
  - Raises EXECUTE and clears the timeout counter.
  - Waits for I2C_READY=0 (FSM has left Idle), then goes to RUN.
- State RUN:
  - EXECUTE stays 1.
  - Each I2C_INCR decrements the byte counter. The counter saturates at 0.
  - LAST_BYTE = (counter==0), registered and updated the cycle after INCR.
  - When I2C_READY=1 (FSM reached Wait), goes to RELEASE.
- State RELEASE:
  - Drops EXECUTE.
  - Holds one cycle so the FSM returns to Idle, then goes to DONE.
- State DONE:
  - Pulses DONE[w] for exactly 1 cycle, with ERR.
  - Clears GNT, READ and WRITE, then returns to ARB.
  - The same requester cannot be regranted before the cycle after DONE. Requesters drop REQ on DONE.
- Timeout:
  - Counter runs in LAUNCH and RUN.
  - At all-ones it forces RELEASE with sticky ERR=1 for this transaction.
  - The next ARB grant still waits for I2C_READY=1; the arbiter never issues EXECUTE to a busy FSM.
- Request timing:
  - A REQ that deasserts before grant is simply not granted.
  - REQ changes during a grant are ignored; command fields are latched only in ARB.
- Byte-count example: a single-byte transaction (LEN=0) has LAST_BYTE=1 from launch. LEN=15 gives 15 INCRs, then the last byte.
- Arbitration ties are resolved by the rr pointer only; there is no fixed priority after reset.
- ARB_STATE encoding: ARB=0, LAUNCH=1, RUN=2, RELEASE=3, DONE=4.

Decomposition:
- Shared package i2c_pkg holds:
  - the arbiter state encodings (3-bit constants);
  - LEN_W=4, DEV_W=7, REG_W=8;
  - an I2C command struct/typedef {rd, dev, reg, len} reused by requesters.
- One sub-module: rr_pick (combinational round-robin priority encoder: REQ plus ptr in, one-hot winner and valid out).
- Sequencer and counters stay in the top module.

Test Plan:
- Single write, requester 2, LEN=3, FSM model emits 3 INCRs:
  - GNT=0100, EXECUTE=1, WRITE=1.
  - LAST_BYTE rises the cycle after the 3rd INCR.
  - DONE=0100 for 1 cycle with ERR=0.
  - EXECUTE drops one cycle before DONE.
- All four REQ set continuously after reset: grants in order 0,1,2,3,0, with no grant overlap and GNT idle in ARB between grants.
- Read with LEN=0: LAST_BYTE=1 on the first cycle of LAUNCH, READ=1, zero INCRs needed, DONE after I2C_READY returns.
- FSM model holds I2C_READY=0 forever with TMO_W=4:
  - RELEASE after 15 cycles, DONE with ERR=1.
  - The next request is not granted until I2C_READY=1.
- RST_B=0 asserted during RUN: next cycle EXECUTE=0, GNT=0, no DONE; ptr=0 afterwards (requester 0 wins a tie).
- I2C_READY=0 at request time: no grant until READY returns; requester 3 gets GNT two cycles after READY rises if ptr=3.
